// File: rtl/fifo_pack_pkg.sv
// fifo_pack_pkg: shared state encoding and counter width for the FIFO word packer.
package fifo_pack_pkg;
    typedef enum logic {FILL, HOLD} pack_state_t;
    localparam int COUNT_W = 16;
endpackage

// File: rtl/pack_idle_timer.sv
// pack_idle_timer: counts idle cycles and pulses expire on the TIMEOUT-th one.
module pack_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT);
    logic [W-1:0] idle_cnt;
    assign expire = en & (idle_cnt == W'(TIMEOUT - 1));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) idle_cnt <= '0;
        else if (clr | expire) idle_cnt <= '0;
        else if (en) idle_cnt <= idle_cnt + 1'b1;
endmodule

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains FIFO entries into LANES-wide words with keep/last,
// closing partial words on flush or idle timeout.
module fifo_word_packer
    import fifo_pack_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fifo_empty,
    input  logic                        fifo_valid,
    input  logic [DATA_WIDTH-1:0]       fifo_data,
    output logic                        fifo_rd_en,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH*LANES-1:0] out_data,
    output logic [LANES-1:0]            out_keep,
    output logic                        out_last,
    output logic                        err,
    output logic [COUNT_W-1:0]          word_count
);
    localparam int LW = $clog2(LANES + 1);
    pack_state_t state;
    logic [LW-1:0] lane_cnt;
    logic rd_pend, flush_pend, cap, flush_go, idle_en, idle_clr, expire;
    logic [LANES-1:0] part_keep;
    // Lanes in flight count against capacity so a word never over-fills.
    assign fifo_rd_en = rst_n & (state == FILL) & !fifo_empty & !flush_pend &
                        ({1'b0, lane_cnt} + (LW+1)'(rd_pend) < (LW+1)'(LANES));
    assign cap      = fifo_valid & rd_pend;
    assign flush_go = (state == FILL) & flush_pend & !rd_pend;
    assign idle_en  = (state == FILL) & (lane_cnt != '0) & !rd_pend & !fifo_valid & fifo_empty;
    assign idle_clr = cap | (state == HOLD);
    always_comb begin
        part_keep = '0;
        for (int i = 0; i < LANES; i++) part_keep[i] = LW'(i) < lane_cnt;
    end
    pack_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (idle_clr),
        .en     (idle_en),
        .expire (expire)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= FILL;
            lane_cnt   <= '0;
            rd_pend    <= 1'b0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_keep   <= '0;
            out_last   <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            rd_pend    <= fifo_rd_en;
            flush_pend <= flush | (flush_pend & !flush_go);
            if (fifo_valid & !rd_pend) err <= 1'b1;
            if (state == FILL) begin
                if (cap) begin
                    out_data[lane_cnt*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
                    lane_cnt <= lane_cnt + 1'b1;
                    if (lane_cnt == LW'(LANES - 1)) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_keep  <= '1;
                        out_last  <= 1'b0;
                    end
                end else if (flush_go) begin
                    if (lane_cnt != '0) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_keep  <= part_keep;
                        out_last  <= 1'b1;
                    end
                end else if (expire) begin
                    state     <= HOLD;
                    out_valid <= 1'b1;
                    out_keep  <= part_keep;
                    out_last  <= 1'b0;
                end
            end else if (out_ready) begin
                state      <= FILL;
                out_valid  <= 1'b0;
                lane_cnt   <= '0;
                out_data   <= '0;
                out_keep   <= '0;
                out_last   <= 1'b0;
                word_count <= word_count + 1'b1;
            end
        end
endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: directed checks of packing, backpressure, flush, timeout,
// reset and spurious-valid handling against a simple one-cycle-latency FIFO model.
module tb_fifo_word_packer;
    logic        clk, rst_n, fifo_empty, fifo_valid, fifo_rd_en, flush;
    logic        out_valid, out_ready, out_last, err;
    logic [7:0]  fifo_data;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic [15:0] word_count;
    logic [7:0]  q[$];
    logic        will_pop;
    int          n_chk = 0, n_pass = 0;

    fifo_word_packer #(.DATA_WIDTH(8), .LANES(4), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_valid (fifo_valid),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // One clock: the pop decision is what the DUT samples at the edge; FIFO
    // outputs for the following cycle are applied at the falling edge.
    task automatic tick();
        #1 will_pop = fifo_rd_en & (q.size() != 0);
        @(posedge clk);
        @(negedge clk);
        fifo_valid = will_pop;
        if (will_pop) fifo_data = q.pop_front();
        fifo_empty = (q.size() == 0);
        flush = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, bad, saw;
        clk = 0; rst_n = 0; fifo_empty = 1; fifo_valid = 0; fifo_data = 0;
        flush = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        #1;
        check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_keep", {28'd0, out_keep}, 32'd0);
        check("rst_last_err", {30'd0, out_last, err}, 32'd0);
        check("rst_wc", {16'd0, word_count}, 32'd0);
        // full word
        @(negedge clk);
        rst_n = 1; out_ready = 1;
        wait_valid(n);
        check("full_lat", n, 32'd5);
        check("full_data", out_data, 32'h44332211);
        check("full_keep", {28'd0, out_keep}, 32'hF);
        check("full_last", {31'd0, out_last}, 32'd0);
        tick();
        check("full_wc", {16'd0, word_count}, 32'd1);
        check("full_clr", {31'd0, out_valid}, 32'd0);
        // backpressure
        out_ready = 0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_valid(n);
        bad = 0;
        repeat (20) begin
            tick();
            if (!out_valid || out_data !== 32'h04030201 || fifo_rd_en) bad++;
        end
        check("bp_stable", bad, 32'd0);
        check("bp_fifo_cnt", q.size(), 32'd4);
        out_ready = 1;
        check("bp_word1", out_data, 32'h04030201);
        tick();
        check("bp_wc1", {16'd0, word_count}, 32'd2);
        wait_valid(n);
        check("bp_word2", out_data, 32'h08070605);
        check("bp_keep2", {28'd0, out_keep}, 32'hF);
        tick();
        check("bp_wc2", {16'd0, word_count}, 32'd3);
        // flush
        push(8'hA1); push(8'hA2); push(8'hA3);
        repeat (5) tick();
        flush = 1;
        wait_valid(n);
        check("fl_lat", n, 32'd2);
        check("fl_data", out_data, 32'h00A3A2A1);
        check("fl_keep", {28'd0, out_keep}, 32'h7);
        check("fl_last", {31'd0, out_last}, 32'd1);
        tick();
        check("fl_wc", {16'd0, word_count}, 32'd4);
        flush = 1;
        saw = 0;
        repeat (4) begin
            tick();
            if (out_valid) saw = 1;
        end
        check("fl_empty", saw, 32'd0);
        check("fl_empty_wc", {16'd0, word_count}, 32'd4);
        // timeout
        push(8'h5A); push(8'h5B);
        repeat (3) tick();
        wait_valid(n);
        check("to_lat", n, 32'd16);
        check("to_data", out_data, 32'h00005B5A);
        check("to_keep", {28'd0, out_keep}, 32'h3);
        check("to_last", {31'd0, out_last}, 32'd0);
        tick();
        check("to_wc", {16'd0, word_count}, 32'd5);
        // reset mid-fill
        push(8'h11); push(8'h22);
        repeat (3) tick();
        rst_n = 0;
        #1;
        check("mr_valid", {31'd0, out_valid}, 32'd0);
        check("mr_data", out_data, 32'd0);
        check("mr_keep", {28'd0, out_keep}, 32'd0);
        check("mr_wc", {16'd0, word_count}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_valid(n);
        check("mr_lat", n, 32'd5);
        check("mr_word", out_data, 32'h44332211);
        tick();
        // spurious valid
        fifo_valid = 1; fifo_data = 8'hEE;
        tick();
        check("sp_err", {31'd0, err}, 32'd1);
        check("sp_valid", {31'd0, out_valid}, 32'd0);
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        wait_valid(n);
        check("sp_word", out_data, 32'hC4C3C2C1);
        check("sp_keep", {28'd0, out_keep}, 32'hF);
        tick();
        check("sp_sticky", {31'd0, err}, 32'd1);
        check("sp_wc", {16'd0, word_count}, 32'd2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Downstream drain stage for the byte FIFO. It pops `DATA_WIDTH`-bit entries from the FIFO read port and packs `LANES` of them into one wide word. It presents each word on a valid/ready output with per-lane keep bits. Partial words leave on an explicit flush or after an idle timeout.

## Interface
- `DATA_WIDTH`, 8, width of one FIFO entry (one lane)
- `LANES`, 4, lanes per output word (≥2)
- `TIMEOUT`, 16, idle cycles before a partial word is emitted (≥2)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_valid`  in  1  FIFO read data valid, one cycle after `fifo_rd_en`
- `fifo_data`  in  DATA_WIDTH  FIFO read data
- `fifo_rd_en`  out  1  FIFO pop request (combinational)
- `flush`  in  1  single-cycle pulse; emit the pending partial word
- `out_valid`  out  1  packed word available
- `out_ready`  in  1  consumer accepts the word
- `out_data`  out  DATA_WIDTH*LANES  packed word; lane 0 is in the LSBs
- `out_keep`  out  LANES  lane-valid mask
- `out_last`  out  1  word was closed by `flush`
- `err`  out  1  sticky flag: `fifo_valid` arrived with no read outstanding
- `word_count`  out  16  number of accepted words; wraps

## Operation
- **States:** FILL (collect lanes) and HOLD (word presented).
- **Registered state:** `lane_cnt`, `rd_pend` (a pop was issued last cycle), `flush_pend`, `idle_cnt`.
- **Pop request:**
  - `fifo_rd_en = (state==FILL) & !fifo_empty & !flush_pend & (lane_cnt + rd_pend < LANES)`.
  - The FIFO's `empty` must already reflect pops issued on earlier edges.
- **Lane capture:** on `fifo_valid` with `rd_pend`=1, `fifo_data` is written into lane `lane_cnt` and `lane_cnt` increments.
  - When `lane_cnt` reaches LANES: go to HOLD with `out_keep` all ones and `out_last`=0.
- **Flush:**
  - `flush` sets `flush_pend`.
  - Once `rd_pend`=0 and `lane_cnt`>0: go to HOLD with `out_keep=(1<<lane_cnt)-1` and `out_last`=1.
  - If `lane_cnt`=0, `flush_pend` clears and no word is produced.
  - A flush arriving in HOLD is held until FILL.
- **Timeout:**
  - `idle_cnt` counts cycles in FILL where `lane_cnt`>0, `rd_pend`=0, `fifo_valid`=0 and `fifo_empty`=1. Any capture resets it.
  - When it reaches TIMEOUT-1: go to HOLD with partial keep and `out_last`=0.
  - Flush wins if both trigger in the same cycle.
- **Output word:** unused lanes read zero. `out_data`, `out_keep` and `out_last` are stable while `out_valid`=1.
- **HOLD exit:** on `out_valid & out_ready`, go to FILL, clear `lane_cnt`, `idle_cnt`, `out_keep`, `out_data` and `out_last`, and increment `word_count`.
- **Spurious valid:** `fifo_valid` with `rd_pend`=0 drops the byte and sets `err`. `err` clears only on reset.
- **Reset:** values stated here and under Timing are reset values (asynchronous assert).
  - `out_valid`, `out_data`, `out_keep`, `out_last`, `err` and `word_count` are 0.
  - `state`=FILL; `lane_cnt`, `rd_pend`, `flush_pend` and `idle_cnt` are 0.
  - `fifo_rd_en` is therefore 0 until `rst_n` rises.
  - Reset during an operation discards partial lanes and any in-flight byte.

## Timing
- A pop sampled at edge t produces `fifo_valid` in cycle t+1; the lane is stored at edge t+1.
- With the FIFO never empty, one pop per cycle. The LANES-th `fifo_valid` edge raises `out_valid` in the next cycle.
  - Full-word latency: LANES+1 cycles from the first pop.
- No pops are issued in HOLD. There is one dead cycle per word: HOLD→FILL, then the next pop.
- A flush takes effect at most 2 cycles after the pulse (one in-flight byte drains first).
- The timeout word appears exactly TIMEOUT cycles after the last capture, given the FIFO is empty throughout.

## Structure
- **Package `fifo_pack_pkg`:** the FILL/HOLD state enum and the `word_count` width constant.
- **Sub-module `pack_idle_timer`:** the `idle_cnt` counter with clear/enable/expire, parameterised by TIMEOUT.
- **Top:** lane datapath and control.

## Test plan
- **Full word:** push 0x11, 0x22, 0x33, 0x44 with `out_ready`=1 → `out_data`=0x44332211, `out_keep`=4'b1111, `out_last`=0, `word_count`=1.
- **Backpressure:** push bytes 0x01–0x08 with `out_ready`=0 for 20 cycles → first word 0x04030201 held stable; `fifo_rd_en` stays 0; FIFO count stays 4. Raise ready → 0x04030201, then 0x08070605.
- **Flush:** push 0xA1, 0xA2, 0xA3, then pulse `flush` → `out_data`=0x00A3A2A1, `out_keep`=4'b0111, `out_last`=1. A flush with no lanes produces no word.
- **Timeout:** push 0x5A, 0x5B, then idle → word 0x00005B5A with `out_keep`=4'b0011, `out_last`=0, exactly 16 cycles after the second capture.
- **Reset mid-fill:** 2 bytes captured, then pulse `rst_n` low → all outputs 0. The next 0x11–0x44 yields a clean 0x44332211.
- **Spurious valid:** drive `fifo_valid`=1 with no pop outstanding → `err`=1, lane count unchanged, a subsequent word is correct.
